uart_echo_checker: RTL and testbench
====================================

// Module: uart_echo_checker
// PURPOSE
//  Host-side peer of the UART echo top (uart_tx/uart_rx loopback). Serializes a known byte sequence
//  onto the DUT receive line, deserializes the echoed bytes from the DUT transmit line, compares each,
//  and reports pass/fail plus error count. Used in FPGA self-test builds and as a bench driver.
// PARAMETERS
//  CLKS_PER_BIT  434    clk cycles per UART bit (50 MHz / 115200); must be >= 4
//  NUM_BYTES     256    bytes sent per run, 1..65535
//  TIMEOUT_CLKS  16384  max clks from end of our stop bit to echo start-bit detection
// PORTS
//  clk         in   1   single clock
//  resetn      in   1   synchronous, ACTIVE-HIGH reset (1 = reset), sampled on clk rising edge
//  start_i     in   1   1-cycle pulse starts a run; ignored while busy_o=1
//  tx_o        out  1   serial out, drives DUT rx_i; idle high
//  rx_i        in   1   serial in, from DUT tx_o; asynchronous to clk
//  busy_o      out  1   run in progress
//  done_o      out  1   run finished; held until next accepted start_i
//  pass_o      out  1   valid when done_o=1: 1 iff err_cnt_o==0
//  err_cnt_o   out  16  errors this run, saturates at 16'hFFFF
//  byte_cnt_o  out  16  bytes completed (checked or timed out) this run
// BEHAVIOUR
//  Reset: tx_o=1, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, byte_cnt_o=0, FSM=IDLE, rx deserializer idle.
//   Reset mid-frame: tx_o=1 from the next cycle; partial frames discarded.
//  Frame: 8N1, LSB first; start 0, 8 data, stop 1; every bit exactly CLKS_PER_BIT clks.
//  Pattern: byte k (k=0..NUM_BYTES-1) = k[7:0] ^ 8'h5A.
//  FSM (stop-and-wait, one byte outstanding):
//   IDLE : start_i -> clear err/byte counts, done_o=0, busy_o=1, k=0, -> SEND.
//   SEND : shift frame for byte k; after last stop-bit clk -> WAIT, timeout counter=0.
//   WAIT : rx frame complete -> CHECK; counter reaches TIMEOUT_CLKS with no start bit detected ->
//          err++ , -> NEXT. Timeout counter freezes once a start bit is detected.
//          Both in same cycle: rx completion wins.
//   CHECK: 1 cycle; err++ if rx byte != expected or rx stop bit was 0 (framing). -> NEXT.
//   NEXT : byte_cnt++, k++; k==NUM_BYTES -> DONE else -> SEND.
//   DONE : 1 cycle; busy_o=0, done_o=1, pass_o=(err_cnt==0) -> IDLE.
//  RX path: rx_i through 2-FF synchronizer (reset value 1). Falling edge while idle -> wait
//   CLKS_PER_BIT/2, resample; still 0 = start, else false start, return to hunt. Data and stop sampled
//   every CLKS_PER_BIT after that midpoint. Completion strobe 1 cycle after stop sample; receiver
//   rearms on that same strobe (no extra idle requirement).
//  Spurious byte: rx completion in any state other than WAIT -> err++ (saturating), data dropped.
//  err++ and spurious err in same cycle count as 2 (still saturating).
//  Echo latency of the DUT is irrelevant provided start bit arrives within TIMEOUT_CLKS.
// TESTING
//  CLKS_PER_BIT=8, NUM_BYTES=4, tx_o wired to rx_i, pulse start_i -> bytes 5A,5B,58,59 on tx_o;
//   done_o=1, pass_o=1, err_cnt_o=0, byte_cnt_o=4 after ~4*(10*8)+overhead clks.
//  Same params through uart_echo top (uart_tx/uart_rx) at matching bit rate -> pass_o=1, err_cnt_o=0.
//  rx_i held 1, NUM_BYTES=4, TIMEOUT_CLKS=100 -> each byte times out; done_o=1, err_cnt_o=4, pass_o=0.
//  Loopback with bit 3 of byte index 2 inverted (58 -> 50) -> err_cnt_o=1; stop bit of byte 1
//   forced 0 -> err_cnt_o=1 (framing); glitch low <4 clks on idle rx_i -> no error.
//  start_i pulsed while busy_o=1 -> ignored, counts unchanged; resetn=1 mid-SEND -> tx_o=1 next cycle,
//   all outputs at reset values; subsequent start_i runs cleanly to pass_o=1.
//  Extra echo byte injected during SEND -> err_cnt_o incremented by 1, run still completes NUM_BYTES.

Source files
------------

// File: rtl/uart_echo_checker.sv
// Host-side peer for a UART echo loopback: sends a known byte pattern stop-and-wait,
// deserializes each echo, and tallies mismatches, framing errors, timeouts and stray bytes.
module uart_echo_checker #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_BYTES    = 256,
  parameter int unsigned TIMEOUT_CLKS = 16384
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] byte_cnt_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]   LAST_BYTE = 16'(NUM_BYTES - 1);
  localparam logic [7:0]    PAT_KEY   = 8'h5A;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_NEXT, S_DONE} state_t;
  typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_DONE} rx_state_t;

  state_t      state_q, state_d;
  logic        tx_q, tx_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] k_q, k_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0] err_q, err_d, bcnt_q, bcnt_d;

  rx_state_t   rx_q, rx_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [3:0]  rbit_q, rbit_d;
  logic [7:0]  rshift_q, rshift_d;
  logic        rstop_q, rstop_d;

  logic        rx_fall, rx_done, rx_started;
  logic        load, clr, fsm_err, spurious;
  logic [7:0]  load_byte, exp_byte;
  logic [16:0] err_sum;

  assign rx_fall    = prev_q & ~sync2_q;
  assign rx_done    = (rx_q == R_DONE);
  assign rx_started = (rx_q == R_DATA) || (rx_q == R_DONE);
  assign exp_byte   = k_q[7:0] ^ PAT_KEY;

  // Receiver: midpoint-verified start bit, then one sample per bit period
  always_comb begin
    rx_d     = rx_q;
    rcnt_d   = rcnt_q;
    rbit_d   = rbit_q;
    rshift_d = rshift_q;
    rstop_d  = rstop_q;
    case (rx_q)
      R_HUNT, R_DONE: begin
        rx_d   = rx_fall ? R_START : R_HUNT;
        rcnt_d = '0;
      end
      R_START: begin
        if (rcnt_q == HALF_BIT) begin
          rcnt_d = '0;
          rbit_d = '0;
          rx_d   = sync2_q ? R_HUNT : R_DATA;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rcnt_q == BIT_LAST) begin
          rcnt_d = '0;
          if (rbit_q == 4'd8) begin
            rstop_d = sync2_q;
            rx_d    = R_DONE;
          end else begin
            rshift_d = {sync2_q, rshift_q[7:1]};
            rbit_d   = rbit_q + 4'd1;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: rx_d = R_HUNT;
    endcase
  end

  // Run control: one byte outstanding at a time
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    ccnt_d    = ccnt_q;
    tmo_d     = tmo_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    bcnt_d    = bcnt_q;
    load      = 1'b0;
    load_byte = PAT_KEY;
    clr       = 1'b0;
    fsm_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          clr     = 1'b1;
          bcnt_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          k_d     = '0;
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ccnt_q == BIT_LAST) begin
          ccnt_d = '0;
          if (bit_q == 4'd9) begin
            tx_d    = 1'b1;
            tmo_d   = '0;
            state_d = S_WAIT;
          end else begin
            tx_d    = frame_q[1];
            frame_d = {1'b1, frame_q[9:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (rx_done) begin
          state_d = S_CHECK;
        end else if (!rx_started) begin
          if (tmo_q == TMO_LAST) begin
            fsm_err = 1'b1;
            state_d = S_NEXT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        fsm_err = (rshift_q != exp_byte) || !rstop_q;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        bcnt_d = bcnt_q + 16'd1;
        k_d    = k_q + 16'd1;
        if (k_q == LAST_BYTE) begin
          state_d = S_DONE;
        end else begin
          load      = 1'b1;
          load_byte = (k_q[7:0] + 8'd1) ^ PAT_KEY;
          state_d   = S_SEND;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      frame_d = {1'b1, load_byte, 1'b0};
      tx_d    = 1'b0;
      bit_d   = '0;
      ccnt_d  = '0;
    end

    // A completed frame outside WAIT is a stray byte; it can stack with a run error
    spurious = rx_done && (state_q != S_WAIT);
    err_sum  = 17'(err_q) + 17'(fsm_err) + 17'(spurious);
    if (clr)             err_d = '0;
    else if (err_sum[16]) err_d = 16'hFFFF;
    else                 err_d = err_sum[15:0];

    if (state_q == S_DONE) pass_d = (err_d == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      frame_q  <= '1;
      bit_q    <= '0;
      ccnt_q   <= '0;
      tmo_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      bcnt_q   <= '0;
      rx_q     <= R_HUNT;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      rcnt_q   <= '0;
      rbit_q   <= '0;
      rshift_q <= '0;
      rstop_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      ccnt_q   <= ccnt_d;
      tmo_q    <= tmo_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      bcnt_q   <= bcnt_d;
      rx_q     <= rx_d;
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      rcnt_q   <= rcnt_d;
      rbit_q   <= rbit_d;
      rshift_q <= rshift_d;
      rstop_q  <= rstop_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign byte_cnt_o = bcnt_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: a behavioural echo peer (decode tx_o, reply on rx_i with
// optional faults) and an error-count expectation derived from the fault plan.
module tb_uart_echo_checker;

  localparam int unsigned CPB = 8;
  localparam int unsigned NB  = 4;
  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start_i = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        tx_o, rx_i, busy_o, done_o, pass_o;
  logic [15:0] err_cnt_o, byte_cnt_o;

  assign rx_i = loop_en ? tx_o : rx_drv;

  uart_echo_checker #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .tx_o(tx_o), .rx_i(rx_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .byte_cnt_o(byte_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] txq[$];     // {stop, data} of every frame seen on tx_o
  int mode_a[NB];         // 0 echo, 1 corrupt, 2 bad stop, 3 silent, 4 echo+extra, 5 glitch+echo
  logic [7:0] flip_mask;
  int exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame decoder on tx_o, sampling each bit at its centre
  initial begin : tx_monitor
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx_o;
        end
        repeat (CPB) @(negedge clk);
        txq.push_back({tx_o, d});
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic respond();
    for (int k = 0; k < NB; k++) begin
      int waited;
      logic [7:0] b;
      waited = 0;
      while (txq.size() <= k && waited < 3000) begin
        @(negedge clk);
        waited++;
      end
      check_eq("echo_peer_saw_frame", 32'(txq.size() > k), 32'd1);
      if (txq.size() <= k) return;
      b = txq[k][7:0];
      repeat ($urandom_range(0, 30)) @(negedge clk);
      case (mode_a[k])
        1: send_frame(b ^ flip_mask, 1'b1);
        2: send_frame(b, 1'b0);
        3: ;
        4: begin
          send_frame(b, 1'b1);
          send_frame(8'($urandom_range(0, 255)), 1'b1);
        end
        5: begin
          rx_drv = 1'b0;
          repeat (3) @(negedge clk);
          rx_drv = 1'b1;
          repeat (12) @(negedge clk);
          send_frame(b, 1'b1);
        end
        default: send_frame(b, 1'b1);
      endcase
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_reached", 32'(done_o), 32'd1);
  endtask

  task automatic check_frames();
    check_eq("tx_frame_count", 32'(txq.size()), 32'(NB));
    for (int k = 0; k < NB && k < txq.size(); k++)
      check_eq("tx_frame", 32'(txq[k]), 32'({1'b1, 8'(k) ^ 8'h5A}));
  endtask

  task automatic check_result(input int e);
    check_eq("busy_after_run", 32'(busy_o), 32'd0);
    check_eq("err_cnt", 32'(err_cnt_o), 32'(e));
    check_eq("pass", 32'(pass_o), 32'(e == 0));
    check_eq("byte_cnt", 32'(byte_cnt_o), 32'(NB));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_tx"}, 32'(tx_o), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_done"}, 32'(done_o), 32'd0);
    check_eq({tag, "_pass"}, 32'(pass_o), 32'd0);
    check_eq({tag, "_err"}, 32'(err_cnt_o), 32'd0);
    check_eq({tag, "_bytes"}, 32'(byte_cnt_o), 32'd0);
  endtask

  initial begin : main
    int fixed_modes[3][NB];
    fixed_modes = '{'{0, 0, 1, 0}, '{0, 2, 0, 0}, '{4, 0, 5, 0}};

    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Straight wire loopback
    loop_en = 1'b1;
    txq.delete();
    pulse_start();
    wait_done();
    check_result(0);
    check_frames();

    // Silent peer: every byte times out
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    txq.delete();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done();
    check_result(NB);
    check_frames();

    // Echo peer with planned faults, plus a start pulse while busy
    for (int r = 0; r < 7; r++) begin
      exp_err = 0;
      flip_mask = (r == 0) ? 8'h08 : 8'($urandom_range(1, 255));
      for (int k = 0; k < NB; k++) begin
        int m;
        m = (r < 3) ? fixed_modes[r][k] : int'($urandom_range(0, 5));
        if (k == NB - 1 && m == 4) m = 0;
        mode_a[k] = m;
        if (m >= 1 && m <= 4) exp_err++;
      end
      txq.delete();
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      repeat (10) @(negedge clk);
      pulse_start();
      fork
        respond();
        begin
          repeat ($urandom_range(20, 200)) @(negedge clk);
          start_i = 1'b1;
          @(negedge clk);
          start_i = 1'b0;
          check_eq("busy_after_ignored_start", 32'(busy_o), 32'd1);
          wait_done();
        end
      join
      check_result(exp_err);
      check_frames();
    end

    // Reset in the middle of a frame, then a clean run
    loop_en = 1'b1;
    txq.delete();
    pulse_start();
    repeat (30) @(negedge clk);
    check_eq("mid_send_busy", 32'(busy_o), 32'd1);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    check_reset_state("midreset");
    repeat (100) @(negedge clk);
    txq.delete();
    pulse_start();
    wait_done();
    check_result(0);
    check_frames();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
